result_collector: RTL
=====================

Name: result_collector

Overview:
- Downstream of the four-core multicore array.
- Captures each core's 8-bit ALU result into a per-core holding register.
- A round-robin arbiter merges the held results into one show-ahead output queue, tagging each entry with its core id.
- Presents a valid/ready stream to the consumer and exports per-core busy flags, so upstream logic can gate a core's clock before results would be lost.

Parameters:
NCORE, 4, number of cores merged (core id width is 2 bits at default).
DW, 8, result data width.
DEPTH, 8, output queue entries (power of two, all usable).
CW, 8, width of the drop and total counters.

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-low reset
res_valid  input  NCORE  per-core result strobe, one result per asserted cycle
res_data  input  NCORE*DW  per-core results, core i at bits [i*DW +: DW]
hold_busy  output  NCORE  holding register i is occupied
out_valid  output  1  queue head valid
out_ready  input  1  consumer accepts head
out_data  output  DW  head result
out_core  output  2  head core id
out_empty  output  1  queue count == 0
out_full  output  1  queue count == DEPTH
fifo_count  output  log2(DEPTH)+1  queue occupancy
drop_count  output  CW  saturating count of lost results
total_count  output  CW  wrapping count of results popped

Behaviour:
- Reset (rst low, async): all hold_v=0, rr_ptr=0, queue pointers and count=0, drop_count=0, total_count=0.
  - Resulting outputs: out_valid=0, out_empty=1, out_full=0, out_data=0, out_core=0, hold_busy=0.
  - Reset mid-operation discards all held and queued results; no partial state survives.
- Capture, per core i, each cycle:
  - If res_valid[i] and (!hold_v[i] or core i granted this cycle): hold_d[i] <= result, hold_v[i] <= 1.
  - If res_valid[i] while hold_v[i]=1 and not granted: result dropped; held value unchanged.
  - Granted and no new result: hold_v[i] <= 0.
- Drops: drop_count += number of cores dropping this cycle, saturating at 2^CW-1.
- Arbiter:
  - Candidates: hold_v. Winner is the first set bit scanning rr_ptr, rr_ptr+1, ... mod NCORE.
  - Grant only when (!out_full) or (pop this cycle).
  - On grant: push {core id, hold_d}; rr_ptr <= winner+1 mod NCORE.
  - No grant leaves rr_ptr unchanged. At most one grant per cycle.
- Queue:
  - Synchronous, show-ahead; pointers wrap mod DEPTH.
  - pop = out_valid & out_ready.
  - Push and pop in the same cycle leave count unchanged, including when full.
  - Push into an empty queue becomes visible next cycle; no fall-through.
  - Pop when empty is ignored.
  - out_data/out_core are held stable while out_valid & !out_ready.
- Latency: res_valid at cycle N → hold at N+1 → granted at N+1 → out_valid at N+2 (minimum 2 cycles).
- total_count increments on each pop and wraps at 2^CW.
- Ordering: per-core order is preserved; cross-core order follows round-robin.

Decomposition:
- Shared package holds:
  - NCORE, DW, DEPTH constants.
  - core_id_t (2 bits).
  - result_entry_t {core_id_t core; logic [DW-1:0] data}.
- One sub-module: result_fifo, the show-ahead synchronous queue of result_entry_t with count/full/empty.
- Arbiter and holding registers stay inline.

Test Plan:
- Reset: drive rst low mid-traffic with 3 entries queued → outputs at reset values immediately (async); after release, out_valid=0, fifo_count=0.
- Single path: core 2 issues 0x2A at cycle 5, out_ready=1 → out_valid at cycle 7 with out_data=0x2A, out_core=2; total_count=1 after the pop.
- Fairness: all four cores assert in the same cycle with 0x10, 0x11, 0x12, 0x13, rr_ptr=0 → pops in core order 0,1,2,3; next burst starts at core 0 again (rr_ptr wrapped).
- Back-pressure: out_ready=0, core 0 issues 9 results in consecutive cycles → out_full after 8 entries, hold_busy[0]=1 with the 9th result; a 10th result raises drop_count to 1; out_data is unchanged throughout the stall.
- Full with simultaneous push/pop: queue full, hold_v[1]=1, out_ready=1 for one cycle → one pop and one push, fifo_count stays 8, hold_busy[1]=0.
- Saturation: with CW=2, force 5 drops → drop_count stops at 3.

Source files
------------

// File: rtl/result_collector_pkg.sv
// Shared types and default sizing for the multicore result collector.
package result_collector_pkg;

   localparam int NCORE = 4;
   localparam int DW    = 8;
   localparam int DEPTH = 8;
   localparam int CW    = 8;

   typedef logic [1:0] core_id_t;

   typedef struct packed {
      core_id_t        core;
      logic [DW-1:0]   data;
   } result_entry_t;

endpackage

// File: rtl/result_collector_fifo.sv
// Show-ahead synchronous queue of tagged results; head is valid whenever count is non-zero.
module result_fifo
   import result_collector_pkg::*;
#(
   parameter int  DEPTH = result_collector_pkg::DEPTH,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push_i,
   input  logic          pop_i,
   input  result_entry_t din_i,
   output result_entry_t dout_o,
   output logic [AW:0]   count_o,
   output logic          full_o,
   output logic          empty_o
);

   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   result_entry_t  mem_q [DEPTH];
   logic [AW-1:0]  wr_ptr_q;
   logic [AW-1:0]  rd_ptr_q;
   logic [AW:0]    count_q;
   logic           push_s;
   logic           pop_s;

   // A pop frees the slot that a same-cycle push into a full queue needs.
   always_comb begin
      pop_s  = pop_i & (count_q != '0);
      push_s = push_i & ((count_q != FULL_CNT) | pop_s);
   end

   // Storage, pointers and occupancy.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_s) begin
            mem_q[wr_ptr_q] <= din_i;
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         if (pop_s) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_q <= count_q + (AW + 1)'(1);
            2'b01:   count_q <= count_q - (AW + 1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign dout_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;
   assign full_o  = (count_q == FULL_CNT);
   assign empty_o = (count_q == '0);

endmodule

// File: rtl/result_collector.sv
// Per-core result holding registers merged round-robin into one tagged output queue.
module result_collector
   import result_collector_pkg::*;
#(
   parameter int  NCORE = result_collector_pkg::NCORE,
   parameter int  DW    = result_collector_pkg::DW,
   parameter int  DEPTH = result_collector_pkg::DEPTH,
   parameter int  CW    = result_collector_pkg::CW,
   localparam int AW    = $clog2(DEPTH),
   localparam int PW    = $clog2(NCORE)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NCORE-1:0]    res_valid,
   input  logic [NCORE*DW-1:0] res_data,
   output logic [NCORE-1:0]    hold_busy,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DW-1:0]       out_data,
   output logic [1:0]          out_core,
   output logic                out_empty,
   output logic                out_full,
   output logic [AW:0]         fifo_count,
   output logic [CW-1:0]       drop_count,
   output logic [CW-1:0]       total_count
);

   localparam int DROP_MAX = (1 << CW) - 1;

   logic [NCORE-1:0] hold_v_q, hold_v_d;
   logic [DW-1:0]    hold_data_q [NCORE];
   logic [DW-1:0]    hold_data_d [NCORE];
   logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
   logic [CW-1:0]    drop_q, drop_d;
   logic [CW-1:0]    total_q, total_d;
   logic             gnt_s;
   logic [PW-1:0]    gnt_idx_s;
   logic             pop_s;
   result_entry_t    push_entry_s;
   result_entry_t    head_s;
   logic             fifo_empty_s;
   logic             fifo_full_s;

   assign pop_s = ~fifo_empty_s & out_ready;

   // Round-robin scan from rr_ptr; a grant needs queue room now or a pop freeing it.
   always_comb begin
      logic [PW-1:0] cand;
      logic          hit;
      gnt_s     = 1'b0;
      gnt_idx_s = '0;
      for (int k = 0; k < NCORE; k++) begin
         cand      = PW'((int'(rr_ptr_q) + k) % NCORE);
         hit       = ~gnt_s & hold_v_q[cand];
         gnt_idx_s = hit ? cand : gnt_idx_s;
         gnt_s     = gnt_s | hit;
      end
      gnt_s = gnt_s & (~fifo_full_s | pop_s);
   end

   // A granted holder may reload in the same cycle, so it never drops on that cycle.
   always_comb begin
      logic granted;
      int   ndrop;
      int   sum;
      hold_v_d    = hold_v_q;
      hold_data_d = hold_data_q;
      ndrop       = 0;
      for (int i = 0; i < NCORE; i++) begin
         granted = gnt_s & (gnt_idx_s == PW'(i));
         if (res_valid[i] && (!hold_v_q[i] || granted)) begin
            hold_v_d[i]    = 1'b1;
            hold_data_d[i] = res_data[i*DW +: DW];
         end else if (res_valid[i]) begin
            ndrop = ndrop + 1;
         end else if (granted) begin
            hold_v_d[i] = 1'b0;
         end else begin
            hold_v_d[i] = hold_v_q[i];
         end
      end
      sum     = int'(drop_q) + ndrop;
      drop_d  = (sum > DROP_MAX) ? CW'(DROP_MAX) : CW'(sum);
      rr_ptr_d = gnt_s ? PW'((int'(gnt_idx_s) + 1) % NCORE) : rr_ptr_q;
      total_d  = pop_s ? total_q + CW'(1) : total_q;
      push_entry_s.core = core_id_t'(gnt_idx_s);
      push_entry_s.data = hold_data_q[gnt_idx_s];
   end

   // Holding registers, arbiter pointer and counters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hold_v_q <= '0;
         for (int i = 0; i < NCORE; i++) begin
            hold_data_q[i] <= '0;
         end
         rr_ptr_q <= '0;
         drop_q   <= '0;
         total_q  <= '0;
      end else begin
         hold_v_q    <= hold_v_d;
         hold_data_q <= hold_data_d;
         rr_ptr_q    <= rr_ptr_d;
         drop_q      <= drop_d;
         total_q     <= total_d;
      end
   end

   result_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (gnt_s),
      .pop_i   (pop_s),
      .din_i   (push_entry_s),
      .dout_o  (head_s),
      .count_o (fifo_count),
      .full_o  (fifo_full_s),
      .empty_o (fifo_empty_s)
   );

   assign hold_busy   = hold_v_q;
   assign out_valid   = ~fifo_empty_s;
   assign out_data    = head_s.data;
   assign out_core    = head_s.core;
   assign out_empty   = fifo_empty_s;
   assign out_full    = fifo_full_s;
   assign drop_count  = drop_q;
   assign total_count = total_q;

endmodule
